add_scan: RTL and testbench



---
 rtl/add_scan.sv | 70 +++++++
 tb/tb_add_scan.sv | 109 ++++++++++
 2 files changed

// File: rtl/add_scan.sv
// add_scan: registered a+b shown as multiplexed hex on a common-anode display
// ADD_SCAN_BLANK_EN: blank leading zero digits above digit 0
module add_scan #(
    parameter int WIDTH    = 3,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              hold,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] sel,
    output logic              ovf
);
    localparam int SW = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [15:0][6:0] HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    logic [WIDTH:0]  full;
    logic [SW-1:0]   sum_q, sum_d, upper;
    logic            ovf_d, tick, last, blank;
    logic [DW-1:0]   div_q;
    logic [IW-1:0]   idx_q;
    logic [3:0]      nib;
    logic [6:0]      glyph;
    assign full = {1'b0, a} + {1'b0, b};
    generate
        if (WIDTH + 1 > SW) begin : g_ovf
            assign sum_d = full[SW-1:0];
            assign ovf_d = |full[WIDTH:SW];
        end else begin : g_fit
            assign sum_d = SW'(full);
            assign ovf_d = 1'b0;
        end
    endgenerate
    always_comb begin
        tick  = div_q == DW'(SCAN_DIV - 1);
        last  = idx_q == IW'(DIGITS - 1);
        upper = sum_q >> {idx_q, 2'b00};
        nib   = upper[3:0];
`ifdef ADD_SCAN_BLANK_EN
        blank = idx_q != '0 && upper == '0;
`else
        blank = 1'b0;
`endif
        glyph = blank ? 7'h7F : HEX[nib];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            ovf   <= 1'b0;
            div_q <= '0;
            idx_q <= '0;
            seg   <= 8'hFF;
            sel   <= '1;
        end else begin
            if (!hold) begin
                sum_q <= sum_d;
                ovf   <= ovf_d;
            end
            div_q <= tick ? '0 : div_q + 1'b1;
            idx_q <= tick ? (last ? '0 : idx_q + 1'b1) : idx_q;
            sel   <= ~(DIGITS'(1) << idx_q);
            seg   <= {~(last && ovf), glyph};
        end
    end
endmodule

// File: tb/tb_add_scan.sv
// tb_add_scan: three add_scan configurations checked against a frame-position reference model
module tb_add_scan;
    localparam int SD = 4;
    logic clk = 0, rst = 1, hold = 0;
    always #5 clk = ~clk;
    int av[3], bv[3];
    int dg[3] = '{2, 2, 1};
    int wd[3] = '{3, 8, 4};
    logic [7:0] sg[3];
    logic [7:0] sl[3];
    logic [1:0] sel0, sel1;
    logic [0:0] sel2;
    logic [2:0] ov;
    logic [7:0] hexv[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int ms[3], mo[3], k[3];
    int tests = 0, fails = 0;
    add_scan #(.WIDTH(3), .DIGITS(2), .SCAN_DIV(SD)) u0 (.clk(clk), .rst(rst), .a(3'(av[0])), .b(3'(bv[0])),
        .hold(hold), .seg(sg[0]), .sel(sel0), .ovf(ov[0]));
    add_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(SD)) u1 (.clk(clk), .rst(rst), .a(8'(av[1])), .b(8'(bv[1])),
        .hold(hold), .seg(sg[1]), .sel(sel1), .ovf(ov[1]));
    add_scan #(.WIDTH(4), .DIGITS(1), .SCAN_DIV(SD)) u2 (.clk(clk), .rst(rst), .a(4'(av[2])), .b(4'(bv[2])),
        .hold(hold), .seg(sg[2]), .sel(sel2), .ovf(ov[2]));
    assign sl[0] = {6'b0, sel0};
    assign sl[1] = {6'b0, sel1};
    assign sl[2] = {7'b0, sel2};

    function automatic logic [7:0] exp_seg(int sum, int o, int d, int nd);
        logic [7:0] s;
        s = hexv[(sum >> (4 * d)) & 15];
`ifdef ADD_SCAN_BLANK_EN
        if (d > 0 && (sum >> (4 * d)) == 0) s = 8'hFF;
`endif
        if (d == nd - 1 && o != 0) s[7] = 1'b0;
        return s;
    endfunction

    task automatic check(string tag, int i, logic [7:0] got, logic [7:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s dut%0d: got %h want %h", tag, i, got, want);
        end
    endtask

    task automatic step();
        logic [7:0] es, esel;
        int d, t;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                k[i] = 0; ms[i] = 0; mo[i] = 0;
                es = 8'hFF; esel = 8'((1 << dg[i]) - 1);
            end else begin
                k[i]++;
                d = ((k[i] - 1) / SD) % dg[i];
                es = exp_seg(ms[i], mo[i], d, dg[i]);
                esel = 8'(((1 << dg[i]) - 1) & ~(1 << d));
                if (!hold) begin
                    t = av[i] + bv[i];
                    ms[i] = t % (1 << (4 * dg[i]));
                    mo[i] = (t >> (4 * dg[i])) != 0 ? 1 : 0;
                end
            end
            check("seg", i, sg[i], es);
            check("sel", i, sl[i], esel);
            check("ovf", i, {7'b0, ov[i]}, 8'(mo[i]));
        end
    endtask

    task automatic set_ops(int a0, int b0, int a1, int b1, int a2, int b2);
        av[0] = a0; bv[0] = b0; av[1] = a1; bv[1] = b1; av[2] = a2; bv[2] = b2;
    endtask

    initial begin
        set_ops(0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 0;
        repeat (16) step();
        set_ops(5, 6, 200, 100, 15, 1);
        repeat (16) step();
        set_ops(7, 7, 7, 7, 7, 7);
        repeat (8) step();
        hold = 1;
        set_ops(1, 1, 1, 1, 1, 1);
        repeat (16) step();
        hold = 0;
        repeat (16) step();
        set_ops(5, 6, 200, 100, 15, 1);
        while (((k[0] - 1) / SD) % 2 != 1) step();
        step();
        rst = 1;
        step();
        rst = 0;
        repeat (12) step();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                av[i] = $urandom_range(0, (1 << wd[i]) - 1);
                bv[i] = $urandom_range(0, (1 << wd[i]) - 1);
            end
            hold = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 60) == 0);
            repeat ($urandom_range(1, 6)) step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
